// File: rtl/bank_axi3_rd_arbiter_if.sv
// Purpose: bundles the four-bank AR/R channels and the shared downstream AXI3 read port.
// Latency: none, this is wiring only.
// Backpressure: carries the valid/ready pairs in both directions unchanged.
interface bank_axi3_rd_arbiter_if;
    // bank side AR
    logic [3:0]   bank_arvalid_i;
    logic [3:0]   bank_arready_o;
    logic [31:0]  bank_arid_i;
    logic [127:0] bank_araddr_i;
    logic [15:0]  bank_arlen_i;
    logic [11:0]  bank_arsize_i;
    logic [7:0]   bank_arburst_i;
    // bank side R
    logic [3:0]   bank_rvalid_o;
    logic [3:0]   bank_rready_i;
    logic [7:0]   bank_rid_o;
    logic [255:0] bank_rdata_o;
    logic [1:0]   bank_rresp_o;
    logic         bank_rlast_o;
    // memory side AR
    logic         mem_arvalid_o;
    logic         mem_arready_i;
    logic [9:0]   mem_arid_o;
    logic [31:0]  mem_araddr_o;
    logic [3:0]   mem_arlen_o;
    logic [2:0]   mem_arsize_o;
    logic [1:0]   mem_arburst_o;
    // memory side R
    logic         mem_rvalid_i;
    logic         mem_rready_o;
    logic [9:0]   mem_rid_i;
    logic [255:0] mem_rdata_i;
    logic [1:0]   mem_rresp_i;
    logic         mem_rlast_i;
    // status
    logic         err_o;

    // The arbiter's view of the bus.
    modport slave (
        input  bank_arvalid_i, bank_arid_i, bank_araddr_i, bank_arlen_i,
               bank_arsize_i, bank_arburst_i, bank_rready_i,
               mem_arready_i, mem_rvalid_i, mem_rid_i, mem_rdata_i,
               mem_rresp_i, mem_rlast_i,
        output bank_arready_o, bank_rvalid_o, bank_rid_o, bank_rdata_o,
               bank_rresp_o, bank_rlast_o, mem_arvalid_o, mem_arid_o,
               mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
               mem_rready_o, err_o
    );

    // The surrounding banks and memory's view of the bus.
    modport master (
        output bank_arvalid_i, bank_arid_i, bank_araddr_i, bank_arlen_i,
               bank_arsize_i, bank_arburst_i, bank_rready_i,
               mem_arready_i, mem_rvalid_i, mem_rid_i, mem_rdata_i,
               mem_rresp_i, mem_rlast_i,
        input  bank_arready_o, bank_rvalid_o, bank_rid_o, bank_rdata_o,
               bank_rresp_o, bank_rlast_o, mem_arvalid_o, mem_arid_o,
               mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
               mem_rready_o, err_o
    );
endinterface

// File: rtl/bank_axi3_rd_arbiter.sv
// Purpose: round-robin AR arbiter for four cache banks onto one AXI3 read port, R routed back by ID prefix.
// Latency: AR one cycle (registered output stage); R zero cycles (combinational).
// Backpressure: AR register holds while mem_arready_i is low; R ready is the owning bank's rready.
module bank_axi3_rd_arbiter #(
    parameter int MAX_OUTSTD = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    bank_axi3_rd_arbiter_if.slave   bus
);

    logic       load_en;
    logic [3:0] elig;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic [1:0] scan_idx;
    logic [1:0] rr_ptr;
    logic [3:0] outstd [4];
    logic [3:0] cnt_inc;
    logic [3:0] cnt_dec;
    logic [1:0] r_bank;
    logic       r_last_hs;
    logic       err_q;

    // The output register may take a new request when empty or being drained this cycle.
    assign load_en = !bus.mem_arvalid_o || bus.mem_arready_i;

    // A bank competes only while it has room for another outstanding burst.
    always_comb begin
        elig = '0;
        for (int n = 0; n < 4; n++) begin
            elig[n] = bus.bank_arvalid_i[n] && (outstd[n] < 4'(MAX_OUTSTD));
        end
    end

    // Round-robin pick: scan far-to-near from rr_ptr so the nearest eligible bank wins.
    always_comb begin
        gnt_idx  = rr_ptr;
        gnt_vld  = 1'b0;
        scan_idx = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr + 2'(k);
            if (elig[scan_idx]) begin
                gnt_idx = scan_idx;
                gnt_vld = 1'b1;
            end
        end
        if (!load_en || rst_i) begin
            gnt_vld = 1'b0;
        end
        grant = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    assign bus.bank_arready_o = grant;

    // Registered AR stage: load the granted bank, clear valid when nothing was granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.mem_arvalid_o <= 1'b0;
            bus.mem_arid_o    <= '0;
            bus.mem_araddr_o  <= '0;
            bus.mem_arlen_o   <= '0;
            bus.mem_arsize_o  <= '0;
            bus.mem_arburst_o <= '0;
        end else if (load_en) begin
            if (gnt_vld) begin
                bus.mem_arvalid_o <= 1'b1;
                bus.mem_arid_o    <= {gnt_idx, bus.bank_arid_i[{gnt_idx, 3'b000} +: 8]};
                bus.mem_araddr_o  <= bus.bank_araddr_i[{gnt_idx, 5'b00000} +: 32];
                bus.mem_arlen_o   <= bus.bank_arlen_i[{gnt_idx, 2'b00} +: 4];
                bus.mem_arsize_o  <= bus.bank_arsize_i[4'(gnt_idx) * 4'd3 +: 3];
                bus.mem_arburst_o <= bus.bank_arburst_i[{gnt_idx, 1'b0} +: 2];
            end else begin
                bus.mem_arvalid_o <= 1'b0;
            end
        end
    end

    // Pointer moves past the bank just served; it holds on stall or idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= 2'd0;
        end else if (gnt_vld) begin
            rr_ptr <= gnt_idx + 2'd1;
        end
    end

    // R channel is pure steering on the ID prefix; payload goes to every bank.
    assign r_bank            = bus.mem_rid_i[9:8];
    assign bus.mem_rready_o  = bus.bank_rready_i[r_bank];
    assign bus.bank_rvalid_o = bus.mem_rvalid_i ? (4'b0001 << r_bank) : 4'b0000;
    assign bus.bank_rid_o    = bus.mem_rid_i[7:0];
    assign bus.bank_rdata_o  = bus.mem_rdata_i;
    assign bus.bank_rresp_o  = bus.mem_rresp_i;
    assign bus.bank_rlast_o  = bus.mem_rlast_i;
    assign r_last_hs         = bus.mem_rvalid_i && bus.mem_rready_o && bus.mem_rlast_i;

    // Per-bank up/down strobes; a last beat for an idle bank never underflows.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int n = 0; n < 4; n++) begin
            cnt_inc[n] = grant[n];
            cnt_dec[n] = r_last_hs && (r_bank == 2'(n)) && (outstd[n] != 4'd0);
        end
    end

    // Outstanding counters: count from grant, release on last beat, cancel when both hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < 4; n++) begin
                outstd[n] <= 4'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (cnt_inc[n] && !cnt_dec[n]) begin
                    outstd[n] <= outstd[n] + 4'd1;
                end else if (cnt_dec[n] && !cnt_inc[n]) begin
                    outstd[n] <= outstd[n] - 4'd1;
                end
            end
        end
    end

    // Sticky flag for a last beat that no bank was waiting for.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (r_last_hs && (outstd[r_bank] == 4'd0)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;

endmodule

// File: doc/bank_axi3_rd_arbiter.md
# bank_axi3_rd_arbiter

Shares one downstream AXI3 read port between the four cache banks. Each bank's AR requests are arbitrated round-robin and issued through a registered AR stage, with the bank index prepended to the transaction ID. Returning R beats are routed back to the owning bank by that ID prefix. A per-bank outstanding-burst counter throttles each bank. The block sits between the bank_top instances' biu_axi3 read channels and the external memory read port.

## Interface

Parameters:
- MAX_OUTSTD, 4: maximum outstanding read bursts per bank; legal range 1..15.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- bank_arvalid_i  in  4  per-bank AR valid; bit n belongs to bank n.
- bank_arready_o  out  4  per-bank AR ready; at most one bit is set.
- bank_arid_i  in  32  per-bank arid; bank n uses [8n+7:8n].
- bank_araddr_i  in  128  per-bank araddr; bank n uses [32n+31:32n].
- bank_arlen_i  in  16  per-bank arlen, 4 bits each.
- bank_arsize_i  in  12  per-bank arsize, 3 bits each.
- bank_arburst_i  in  8  per-bank arburst, 2 bits each.
- bank_rvalid_o  out  4  per-bank R valid.
- bank_rready_i  in  4  per-bank R ready.
- bank_rid_o  out  8  rid with the bank prefix stripped; common to all banks.
- bank_rdata_o  out  256  rdata; common to all banks.
- bank_rresp_o  out  2  rresp; common to all banks.
- bank_rlast_o  out  1  rlast; common to all banks.
- mem_arvalid_o  out  1  downstream AR valid (registered).
- mem_arready_i  in  1  downstream AR ready.
- mem_arid_o  out  10  {bank index[1:0], bank arid[7:0]}.
- mem_araddr_o  out  32  downstream araddr.
- mem_arlen_o  out  4  downstream arlen.
- mem_arsize_o  out  3  downstream arsize.
- mem_arburst_o  out  2  downstream arburst.
- mem_rvalid_i  in  1  downstream R valid.
- mem_rready_o  out  1  downstream R ready.
- mem_rid_i  in  10  downstream rid.
- mem_rdata_i  in  256  downstream rdata.
- mem_rresp_i  in  2  downstream rresp.
- mem_rlast_i  in  1  downstream rlast.
- err_o  out  1  sticky protocol-error flag.

## Operation

- **AR stage**
  - A single output register holds mem_ar*.
  - load_en = !mem_arvalid_o || mem_arready_i.
- **Eligibility**
  - Bank n is eligible when bank_arvalid_i[n] is high and outstd[n] < MAX_OUTSTD.
- **Arbitration**
  - Round-robin, starting at rr_ptr (2 bits).
  - If load_en is high and any bank is eligible, the first eligible bank at or after rr_ptr (mod 4) is granted.
  - bank_arready_o is the combinational one-hot grant; it is zero whenever load_en is low.
- **On grant of bank g**
  - Register loads mem_arid_o={g, bank_arid_i[g]}, addr/len/size/burst of bank g; mem_arvalid_o is set to 1.
  - rr_ptr becomes g+1 (wraps 3->0).
  - outstd[g] increments.
- **No grant while load_en is high:** mem_arvalid_o clears to 0 and rr_ptr holds.
- **Stall:** while mem_arvalid_o=1 and mem_arready_i=0, the register and rr_ptr hold.
- **R routing (combinational)**
  - b = mem_rid_i[9:8].
  - bank_rvalid_o[n] = mem_rvalid_i && (b==n).
  - mem_rready_o = bank_rready_i[b].
  - Data, resp, last and rid[7:0] are broadcast to all banks.
  - Beats from different IDs may interleave; no R buffering.
- **Outstanding counters**
  - outstd[n] is 4 bits and counts from AR grant, not from downstream acceptance.
  - Decrements on the R handshake (mem_rvalid_i && mem_rready_o && mem_rlast_i) with b==n.
  - A grant and a last-beat for the same bank in one cycle leave the counter unchanged.
  - The counter never exceeds MAX_OUTSTD because eligibility gates grants.
- **Error**
  - A last-beat handshake for a bank whose outstd is 0 sets err_o; that counter stays 0.
  - err_o clears only on reset.
- **Reset**
  - mem_arvalid_o=0, the rest of mem_ar*=0, rr_ptr=0, all outstd=0, err_o=0.
  - bank_arready_o=0 in the cycle rst_i is high.
  - Combinational R outputs follow their inputs.
  - Reset mid-burst discards all tracking state; the downstream port must be reset together with this block.

## Timing

- AR latency: the bank handshake in cycle t puts the request on mem_ar* in cycle t+1.
- AR throughput: one grant per cycle while mem_arready_i is held high.
- A bank's arready may be low for up to 3 consecutive grant cycles (round-robin fairness bound) plus any downstream stall.
- R path has zero-cycle latency; no register between mem_r* and bank_r*.
- Counter and err_o updates are visible in the cycle after the triggering handshake.
- mem_ar* is stable while mem_arvalid_o=1 and mem_arready_i=0, as AXI3 requires.

## Test plan

1. Single request: after reset, bank2 requests arid=0x15, addr=0x1000, len=1; mem_arready_i=1.
   - Required: bank_arready_o=4'b0100 in the request cycle.
   - Next cycle: mem_arvalid_o=1, mem_arid_o=10'h215.
   - Then 2 R beats with rid=10'h215 reach only bank2 with rid 0x15; outstd[2] returns 0.
2. Fairness: all 4 banks request continuously, mem_arready_i=1.
   - Required: grant order 0,1,2,3,0,1,…, one grant per cycle.
3. Back-pressure: mem_arready_i=0 for 5 cycles with bank1 and bank3 requesting.
   - Required: mem_ar* holds the first grant unchanged and bank_arready_o=0 during the stall.
   - On the release cycle the next bank (round-robin order) is granted.
4. Throttle: MAX_OUTSTD=4, bank0 issues 4 bursts with no R return.
   - Required: the fifth request is stalled and bank1's requests are still granted.
   - A single rlast beat for bank0 re-enables it on the next cycle.
5. Simultaneous grant and return: bank3 is granted in the same cycle as an rlast handshake for bank3 with outstd[3]=2.
   - Required: outstd[3] stays 2.
6. Error and reset: an rlast beat arrives with rid prefix 1 while outstd[1]=0.
   - Required: err_o=1 from the next cycle, remaining set until rst_i.
   - A rst_i pulse mid-traffic gives mem_arvalid_o=0, all counters 0, err_o=0.
